// File: rtl/multu_hilo_unit.sv
`default_nettype none
// ============================================================================
// Module   : multu_hilo_unit
// Purpose  : Multi-cycle unsigned shift-add multiplier with a HI/LO result
//            register pair. Executes MULTU (R-type, Funct 25) issued from the
//            EX stage and serves later MFHI/MFLO reads. Raises a stall to the
//            hazard logic whenever a MULTU or MFHI/MFLO arrives while busy.
// Ports    : clk      - rising-edge clock
//            rst      - asynchronous active-high reset
//            start    - MULTU issue pulse (accepted only in IDLE)
//            dataA    - multiplicand (rs), sampled on accepted start
//            dataB    - multiplier (rt), sampled on accepted start
//            rd_req   - MFHI/MFLO wants HI/LO this cycle
//            rd_sel   - 1 = HI, 0 = LO
//            rd_data  - combinational rd_sel ? HI : LO
//            busy     - high while iterating
//            done     - one-cycle pulse after HI/LO commit
//            stall    - unit not idle while a MULTU or HI/LO read is pending
// Revision : 1.0 - initial release
// ============================================================================
module multu_hilo_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic             rd_req,
  input  logic             rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Count value of the final iteration; latency is fixed at WIDTH iterations.
  localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

  state_t               r_state;
  state_t               w_next;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [2*WIDTH-1:0]   r_product;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [CNT_W-1:0]     r_count;

  logic [2*WIDTH-1:0]   w_addend;
  logic [2*WIDTH-1:0]   w_sum;
  logic                 w_last;

  // The product register is wide enough that this sum never overflows.
  assign w_addend = r_mplier[0] ? r_mcand : '0;
  assign w_sum    = r_product + w_addend;
  assign w_last   = (r_count == c_last);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and status outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Any request that arrives while not idle must be held upstream. In IDLE a
  // read is served immediately and a start is accepted on the coming edge.
  assign stall   = (r_state != S_IDLE) & (start | rd_req);
  assign rd_data = rd_sel ? r_hi : r_lo;

  // --------------------------------------------------------------------------
  // Datapath: operand shift registers, accumulator, HI/LO
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_product <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_count   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand   <= {{WIDTH{1'b0}}, dataA};
            r_mplier  <= dataB;
            r_product <= '0;
            r_count   <= '0;
          end
        end
        S_RUN: begin
          r_product <= w_sum;
          r_mcand   <= r_mcand << 1;
          r_mplier  <= r_mplier >> 1;
          r_count   <= r_count + 1'b1;
          // HI/LO hold the previous result until this single commit edge,
          // which includes the add from the final iteration.
          if (w_last) begin
            r_hi <= w_sum[2*WIDTH-1:WIDTH];
            r_lo <= w_sum[WIDTH-1:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire
